// File: rtl/div_sequencer.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Define DIV_SPECIAL_BYPASS_EN to skip CALC for divide-by-zero and signed overflow.
module div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  typedef enum logic [2:0] {
    IDLE, PREP, CALC, FIN, DONE
  } state_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quo, rem, dvs, a_raw;
  logic [1:0]       op_q;
  logic             q_neg, r_neg, dz, ovf;

  logic             sgn, a_neg, b_neg, dz_c, ovf_c;
  logic [WIDTH:0]   rem_ext, diff;
  logic             ge;
  logic [WIDTH-1:0] q_fix, r_fix, fin_val;

  // In PREP, quo/dvs still hold the raw operands.
  assign sgn   = ~op_q[0];
  assign a_neg = sgn & quo[WIDTH-1];
  assign b_neg = sgn & dvs[WIDTH-1];
  assign dz_c  = (dvs == '0);
  assign ovf_c = sgn & (quo == MIN_NEG) & (dvs == '1);

  // One extra bit keeps the trial compare exact for divisors >= 2^(WIDTH-1).
  assign rem_ext = {rem, quo[WIDTH-1]};
  assign diff    = rem_ext - {1'b0, dvs};
  assign ge      = (rem_ext >= {1'b0, dvs});

  assign q_fix = q_neg ? (~quo + 1'b1) : quo;
  assign r_fix = r_neg ? (~rem + 1'b1) : rem;

  always_comb begin
    fin_val = op_q[1] ? r_fix : q_fix;
    if (dz) begin
      fin_val = op_q[1] ? a_raw : '1;
    end else if (ovf) begin
      fin_val = op_q[1] ? '0 : MIN_NEG;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE: if (start_i) next = PREP;
`ifdef DIV_SPECIAL_BYPASS_EN
      PREP: next = (dz_c | ovf_c) ? FIN : CALC;
`else
      PREP: next = CALC;
`endif
      CALC: if (cnt == CNT_W'(1)) next = FIN;
      FIN:  next = DONE;
      DONE: next = IDLE;
      default: next = IDLE;
    endcase
    if (flush_i) next = IDLE;
  end

  assign busy_o = ((state == IDLE) & start_i & ~flush_i)
                | (state == PREP)
                | (state == CALC)
                | (state == FIN);
  assign done_o = (state == DONE) & ~flush_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt      <= '0;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      a_raw    <= '0;
      op_q     <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      dz       <= 1'b0;
      ovf      <= 1'b0;
      result_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i && !flush_i) begin
            quo   <= dividend_i;
            a_raw <= dividend_i;
            dvs   <= divisor_i;
            op_q  <= op_i;
          end
        end
        PREP: begin
          quo   <= a_neg ? (~quo + 1'b1) : quo;
          dvs   <= b_neg ? (~dvs + 1'b1) : dvs;
          rem   <= '0;
          q_neg <= a_neg ^ b_neg;
          r_neg <= a_neg;
          dz    <= dz_c;
          ovf   <= ovf_c;
          cnt   <= CNT_W'(WIDTH);
        end
        CALC: begin
          quo <= {quo[WIDTH-2:0], ge};
          rem <= ge ? diff[WIDTH-1:0] : rem_ext[WIDTH-1:0];
          cnt <= cnt - 1'b1;
        end
        FIN: begin
          if (!flush_i) result_o <= fin_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: latency, signed fix-up, special cases,
// flush, reset and held start.
module tb_div_sequencer;

  localparam int W = 32;
  localparam int LAT = W + 3;
`ifdef DIV_SPECIAL_BYPASS_EN
  localparam int SLAT = 3;
`else
  localparam int SLAT = W + 3;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         flush;
  logic         busy, done;
  logic [W-1:0] result;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] last_res;

  div_sequencer dut (
    .clk_i      (clk),
    .reset_n_i  (rst_n),
    .start_i    (start),
    .op_i       (op),
    .dividend_i (a),
    .divisor_i  (b),
    .flush_i    (flush),
    .busy_o     (busy),
    .done_o     (done),
    .result_o   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Caller is positioned just after a rising edge; so is the return.
  task automatic do_op(input string tag, input logic [1:0] o,
                       input logic [W-1:0] x, input logic [W-1:0] y,
                       input int lat, input logic [W-1:0] exp,
                       input bit hold);
    int dcyc;
    int pulses;
    logic [W-1:0] res;
    dcyc = -1;
    pulses = 0;
    res = 'x;
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    for (int c = 0; c <= lat + 2; c++) begin
      @(negedge clk);
      if (c == 0)
        chk({tag, " busy0"}, W'(busy), W'(1));
      if (c == lat - 1)
        chk({tag, " busy_last"}, W'(busy), W'(1));
      if (c == lat)
        chk({tag, " busy_done"}, W'(busy), W'(0));
      if (done) begin
        pulses++;
        if (dcyc < 0) begin
          dcyc = c;
          res = result;
        end
      end
      @(posedge clk);
      #1;
      if (!hold || dcyc >= 0) start = 1'b0;
      a = ~a;
      b = b + 1;
      op = ~op;
    end
    chk({tag, " done_cycle"}, W'(dcyc), W'(lat));
    chk({tag, " pulses"}, W'(pulses), W'(1));
    chk({tag, " result"}, res, exp);
    last_res = exp;
  endtask

  initial begin
    int dseen;
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op = 2'b00;
    a = '0;
    b = '0;
    last_res = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst busy", W'(busy), W'(0));
    chk("rst done", W'(done), W'(0));
    chk("rst result", result, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op("divu_100_7", 2'b01, 32'd100, 32'd7, LAT, 32'd14, 1'b0);
    do_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, LAT, 32'hFFFF_FFFF, 1'b0);
    do_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, LAT, 32'hFFFF_FFFD, 1'b0);
    do_op("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE, LAT, 32'hFFFF_FFFD, 1'b0);
    do_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, LAT, 32'd1, 1'b0);
    do_op("divu_big", 2'b01, 32'hFFFF_FFFF, 32'h8000_0001, LAT, 32'd1, 1'b0);
    do_op("remu_big", 2'b11, 32'hFFFF_FFFF, 32'h8000_0001, LAT, 32'h7FFF_FFFE, 1'b0);
    do_op("div_5_0", 2'b00, 32'd5, 32'd0, SLAT, 32'hFFFF_FFFF, 1'b0);
    do_op("remu_5_0", 2'b11, 32'd5, 32'd0, SLAT, 32'd5, 1'b0);
    do_op("rem_m5_0", 2'b10, 32'hFFFF_FFFB, 32'd0, SLAT, 32'hFFFF_FFFB, 1'b0);
    do_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, SLAT, 32'h8000_0000, 1'b0);
    do_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, SLAT, 32'd0, 1'b0);
    do_op("div_hold", 2'b00, 32'd20, 32'd3, LAT, 32'd6, 1'b1);
    do_op("remu_ref", 2'b11, 32'd1000, 32'd7, LAT, 32'd6, 1'b0);

    // Flush during CALC: back to IDLE one cycle later, no done, result kept.
    dseen = 0;
    start = 1'b1;
    op = 2'b01;
    a = 32'd1000;
    b = 32'd3;
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      if (done) dseen++;
      if (c == 10) chk("flush busy10", W'(busy), W'(1));
      if (c == 11) chk("flush busy11", W'(busy), W'(0));
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = (c == 9);
    end
    chk("flush no_done", W'(dseen), W'(0));
    chk("flush result_kept", result, last_res);
    do_op("divu_9_3", 2'b01, 32'd9, 32'd3, LAT, 32'd3, 1'b0);

    // Flush and start together in IDLE: nothing starts.
    start = 1'b1;
    flush = 1'b1;
    op = 2'b01;
    a = 32'd50;
    b = 32'd5;
    @(negedge clk);
    chk("flush_start busy", W'(busy), W'(0));
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_start idle", W'(busy), W'(0));
    @(posedge clk);
    #1;

    // Reset mid-operation.
    start = 1'b1;
    op = 2'b00;
    a = 32'd100;
    b = 32'd7;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    @(negedge clk);
    chk("pre_rst busy", W'(busy), W'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst busy", W'(busy), W'(0));
    chk("mid_rst done", W'(done), W'(0));
    chk("mid_rst result", result, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op("div_after_rst", 2'b00, 32'd100, 32'hFFFF_FFF9, LAT, 32'hFFFF_FFF2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
